// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART FIFO write-side logic.
//
// Contents:
//   arb_state_t           - write arbiter state encoding (IDLE=0, BURST=1)
//   FREE_SPACE_EXTRA_BITS - extra bits needed to hold the free-space value
//   free_space_width()    - free-space width for a given depth width.
//                           A completely empty FIFO has 2**depth_width free
//                           entries, which needs one bit more than the
//                           occupancy count itself.
package uart_fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int FREE_SPACE_EXTRA_BITS = 1;

    function automatic int free_space_width(input int depth_width);
        return depth_width + FREE_SPACE_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
//
// Searches the request vector upward from last+1, wrapping modulo NUM_REQ,
// and returns the first set bit.
//
// Ports:
//   req   in  NUM_REQ  request vector
//   last  in  IDX_W    index granted most recently (search starts above it)
//   found out 1        at least one request bit is set
//   index out IDX_W    selected requester (0 when found=0)
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    int cand;

    // Offsets 1..NUM_REQ visit every requester once; offset NUM_REQ lands
    // back on 'last' itself, so a lone requester can be re-granted.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last) + i) % NUM_REQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_fifo_wr_arbiter.sv
// Write-side arbiter in front of the async UART FIFO.
//
// Several packet sources share the FIFO write port. A source is granted only
// when the FIFO has at least MIN_SPACE free entries; it then owns the port
// until it sends a beat marked last, or until MAX_BURST beats have gone
// through (in which case burst_trunc pulses and the grant moves on).
// Beats pass straight through to the FIFO with no added latency.
//
// Handshake: a beat moves when req_valid[k] && req_ready[k] are both high on
// a rising clk_write edge. req_ready never depends on req_valid; req_valid
// may drop mid-burst, in which case the grant is simply held.
//
// Ports:
//   clk_write          in   write-domain clock
//   rst_n              in   asynchronous active-low reset
//   req_valid          in   NUM_REQ            per-requester beat valid
//   req_data           in   NUM_REQ*DATA_WIDTH requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_last           in   NUM_REQ            beat closes its packet
//   req_ready          out  NUM_REQ            per-requester beat accept
//   fifo_full          in   FIFO full flag
//   fifo_data_count_w  in   FIFO occupancy
//   fifo_write         out  FIFO write strobe
//   fifo_data_write    out  FIFO write data (0 when no beat moves)
//   grant_id           out  current or most recent granted requester
//   busy               out  high while a burst is in progress
//   burst_trunc        out  one-cycle pulse after a burst cut at MAX_BURST
//   dbg_state          out  raw FSM state
module uart_fifo_wr_arbiter
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int FIFO_DEPTH_WIDTH = 11,
    parameter int NUM_REQ          = 4,
    parameter int MIN_SPACE        = 16,
    parameter int MAX_BURST        = 64
) (
    input  logic                          clk_write,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic [FIFO_DEPTH_WIDTH-1:0]   fifo_data_count_w,
    output logic                          fifo_write,
    output logic [DATA_WIDTH-1:0]         fifo_data_write,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          burst_trunc,
    output arb_state_t                    dbg_state
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int FREE_W = free_space_width(FIFO_DEPTH_WIDTH);
    localparam int CNT_W  = $clog2(MAX_BURST + 1);

    localparam logic [FREE_W-1:0] DEPTH_V     = FREE_W'(2 ** FIFO_DEPTH_WIDTH);
    localparam logic [FREE_W-1:0] MIN_SPACE_V = FREE_W'(MIN_SPACE);
    localparam logic [CNT_W-1:0]  LAST_BEAT_V = CNT_W'(MAX_BURST - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    arb_state_t        state, state_d;
    logic [IDX_W-1:0]  grant_d;
    logic [IDX_W-1:0]  last_grant, last_grant_d;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_d;
    logic              trunc_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [FREE_W-1:0]     free_space;
    logic                  space_ok;
    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] sel_data;

    // The full flag wins over the count: the count alone cannot tell a full
    // FIFO from an empty one when it wraps.
    assign free_space = fifo_full ? '0 : (DEPTH_V - {1'b0, fifo_data_count_w});
    assign space_ok   = (free_space >= MIN_SPACE_V);

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req_valid),
        .last  (last_grant),
        .found (pick_found),
        .index (pick_idx)
    );

    assign sel_data = req_data[int'(grant_id) * DATA_WIDTH +: DATA_WIDTH];

    // State resets asynchronously to IDLE, so ready and write drop the
    // instant rst_n falls without any extra gating.
    assign xfer = (state == BURST) && !fifo_full && req_valid[grant_id];

    always_comb begin
        req_ready = '0;
        if (state == BURST) begin
            req_ready[grant_id] = !fifo_full;
        end
    end

    assign fifo_write      = xfer;
    assign fifo_data_write = xfer ? sel_data : '0;
    assign busy            = (state == BURST);
    assign dbg_state       = state;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state;
        grant_d      = grant_id;
        last_grant_d = last_grant;
        beat_cnt_d   = beat_cnt;
        trunc_d      = 1'b0;
        case (state)
            IDLE: begin
                // The selection cycle moves no data; the winner gets
                // ready on the following cycle.
                if (pick_found && space_ok) begin
                    state_d      = BURST;
                    grant_d      = pick_idx;
                    last_grant_d = pick_idx;
                    beat_cnt_d   = '0;
                end
            end
            BURST: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt + 1'b1;
                    if (req_last[grant_id]) begin
                        state_d = IDLE;
                    end else if (beat_cnt == LAST_BEAT_V) begin
                        // Cut the packet so one source cannot hog the port;
                        // its remaining beats compete again from IDLE.
                        state_d = IDLE;
                        trunc_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // last_grant resets to the top index so the first search after reset
    // starts at requester 0.
    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_id    <= '0;
            last_grant  <= IDX_W'(NUM_REQ - 1);
            beat_cnt    <= '0;
            burst_trunc <= 1'b0;
        end else begin
            state       <= state_d;
            grant_id    <= grant_d;
            last_grant  <= last_grant_d;
            beat_cnt    <= beat_cnt_d;
            burst_trunc <= trunc_d;
        end
    end

endmodule

// File: tb/tb_uart_fifo_wr_arbiter.sv
// Self-checking bench for uart_fifo_wr_arbiter (default parameters).
//
// Each requester is a queue of {last, data} beats. tick() drives one cycle of
// inputs on the falling edge, samples the outputs 1 ns later, and keeps a
// transaction-level reference model (idle/burst, granted index, beats so far)
// whose expectations the test tasks compare against the sampled outputs.
module tb_uart_fifo_wr_arbiter;

  localparam int DW        = 8;
  localparam int NR        = 4;
  localparam int MIN_SPACE = 16;
  localparam int MAX_BURST = 64;
  localparam int DEPTH     = 2048;

  // ---------------- clock / reset ----------------
  logic clk_write = 1'b0;
  always #5 clk_write = ~clk_write;

  logic                   rst_n;
  logic [NR-1:0]          req_valid;
  logic [NR*DW-1:0]       req_data;
  logic [NR-1:0]          req_last;
  logic [NR-1:0]          req_ready;
  logic                   fifo_full;
  logic [10:0]            fifo_data_count_w;
  logic                   fifo_write;
  logic [DW-1:0]          fifo_data_write;
  logic [1:0]             grant_id;
  logic                   busy;
  logic                   burst_trunc;
  uart_fifo_pkg::arb_state_t dbg_state;

  uart_fifo_wr_arbiter dut (
    .clk_write         (clk_write),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_last          (req_last),
    .req_ready         (req_ready),
    .fifo_full         (fifo_full),
    .fifo_data_count_w (fifo_data_count_w),
    .fifo_write        (fifo_write),
    .fifo_data_write   (fifo_data_write),
    .grant_id          (grant_id),
    .busy              (busy),
    .burst_trunc       (burst_trunc),
    .dbg_state         (dbg_state)
  );

  // ---------------- sources, scoreboard, model ----------------
  logic [DW:0]   src_q [NR][$];
  logic [DW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic        full_drv;
  logic [10:0] count_drv;
  logic        gap_en;

  bit m_burst, m_trunc;
  int m_g, m_last, m_beats;
  bit pend_valid, pick_found;
  int pick;

  logic [NR-1:0] exp_ready, obs_ready;
  logic          exp_write, obs_write;
  logic [DW-1:0] exp_data, obs_data;
  logic          exp_busy, obs_busy;
  logic [1:0]    exp_grant, obs_grant;
  logic          exp_trunc, obs_trunc;

  function automatic logic [DW-1:0] rnd_byte();
    return DW'($urandom_range(0, 255));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NR; k++) src_q[k].delete();
    exp_q.delete();
    m_burst = 1'b0; m_trunc = 1'b0; m_g = 0; m_last = NR - 1; m_beats = 0;
    pend_valid = 1'b0; pick_found = 1'b0; pick = 0;
    exp_write = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    full_drv = 1'b0; count_drv = '0; gap_en = 1'b0;
    fifo_full = 1'b0; fifo_data_count_w = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk_write);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_write);
    rst_n = 1'b1;
  endtask

  task automatic push_packet(input int k, input int len, input bit with_last, input bit to_sb);
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = rnd_byte();
      src_q[k].push_back({(with_last && i == len - 1), d});
      if (to_sb) exp_q.push_back(d);
    end
  endtask

  // One cycle: commit last cycle's expected outcome, drive, sample, predict.
  task automatic tick();
    logic [DW:0]    beat;
    logic [NR-1:0]  v, l, gap;
    logic [NR*DW-1:0] d;
    int free;
    if (pend_valid) begin
      m_trunc = 1'b0;
      if (m_burst) begin
        if (exp_write) begin
          beat = src_q[m_g].pop_front();
          m_beats++;
          if (beat[DW]) m_burst = 1'b0;
          else if (m_beats == MAX_BURST) begin
            m_burst = 1'b0;
            m_trunc = 1'b1;
          end
        end
      end else if (pick_found) begin
        m_burst = 1'b1; m_g = pick; m_last = pick; m_beats = 0;
      end
    end
    @(negedge clk_write);
    gap = gap_en ? (NR'($urandom_range(0, 15)) & NR'($urandom_range(0, 15))) : '0;
    for (int k = 0; k < NR; k++) begin
      if (src_q[k].size() > 0) begin
        beat = src_q[k][0];
        v[k] = !gap[k];
        d[k*DW +: DW] = beat[DW-1:0];
        l[k] = beat[DW];
      end else begin
        v[k] = 1'b0;
        d[k*DW +: DW] = rnd_byte();
        l[k] = 1'($urandom_range(0, 1));
      end
    end
    req_valid = v; req_data = d; req_last = l;
    fifo_full = full_drv; fifo_data_count_w = count_drv;
    #1;
    free = full_drv ? 0 : DEPTH - int'(count_drv);
    exp_busy = m_burst; exp_grant = 2'(m_g); exp_trunc = m_trunc;
    exp_ready = '0; exp_write = 1'b0; exp_data = '0;
    if (m_burst && !full_drv) begin
      exp_ready[m_g] = 1'b1;
      if (v[m_g]) begin
        beat = src_q[m_g][0];
        exp_write = 1'b1;
        exp_data = beat[DW-1:0];
      end
    end
    pick_found = 1'b0;
    if (!m_burst && free >= MIN_SPACE) begin
      for (int i = 1; i <= NR; i++) begin
        int c;
        c = (m_last + i) % NR;
        if (!pick_found && v[c]) begin
          pick_found = 1'b1;
          pick = c;
        end
      end
    end
    obs_ready = req_ready; obs_write = fifo_write; obs_data = fifo_data_write;
    obs_busy = busy; obs_grant = grant_id; obs_trunc = burst_trunc;
    pend_valid = 1'b1;
    cyc++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    req_valid = '1; req_last = '0; req_data = '1;
    fifo_full = 1'b0; fifo_data_count_w = '0;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset.ready: got %b expected 0000", req_ready); end
    checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL reset.write: got %b expected 0", fifo_write); end
    repeat (2) @(negedge clk_write);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset.busy: got %b expected 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset.grant: got %0d expected 0", grant_id); end
    checks++; if (burst_trunc !== 1'b0) begin errors++; $display("FAIL reset.trunc: got %b expected 0", burst_trunc); end
    checks++; if (fifo_data_write !== '0) begin errors++; $display("FAIL reset.data: got %h expected 00", fifo_data_write); end
    apply_reset();
  endtask

  task automatic test_single_packet();
    int wrs = 0;
    logic [DW-1:0] want;
    apply_reset();
    src_q[0].push_back({1'b0, 8'hA1});
    src_q[0].push_back({1'b0, 8'hA2});
    src_q[0].push_back({1'b1, 8'hA3});
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    for (int t = 0; t < 8; t++) begin
      tick();
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL single.ready cyc %0d: got %b expected %b", cyc, obs_ready, exp_ready); end
      checks++; if (obs_write !== exp_write) begin errors++; $display("FAIL single.write cyc %0d: got %b expected %b", cyc, obs_write, exp_write); end
      checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL single.data cyc %0d: got %h expected %h", cyc, obs_data, exp_data); end
      checks++; if (obs_busy !== exp_busy) begin errors++; $display("FAIL single.busy cyc %0d: got %b expected %b", cyc, obs_busy, exp_busy); end
      checks++; if (obs_trunc !== 1'b0) begin errors++; $display("FAIL single.trunc cyc %0d: got %b expected 0", cyc, obs_trunc); end
      if (t == 0) begin
        checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL single.busy_t0: got %b expected 0", obs_busy); end
      end
      if (t == 1) begin
        checks++; if (obs_busy !== 1'b1 || obs_grant !== 2'd0) begin errors++; $display("FAIL single.grant_t1: got busy %b grant %0d expected busy 1 grant 0", obs_busy, obs_grant); end
      end
      if (obs_write === 1'b1) begin
        wrs++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL single.extra_write: got data %h expected none", obs_data); end
        else begin
          want = exp_q.pop_front();
          if (obs_data !== want) begin errors++; $display("FAIL single.sb_data: got %h expected %h", obs_data, want); end
        end
      end
    end
    checks++; if (wrs != 3) begin errors++; $display("FAIL single.write_count: got %0d expected 3", wrs); end
    checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL single.end_idle: got busy %b expected 0", obs_busy); end
  endtask

  task automatic test_round_robin();
    int grants[$];
    int rise_at[$];
    bit prev_busy = 1'b0;
    int want[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    push_packet(0, 1, 1'b1, 1'b0);
    push_packet(0, 1, 1'b1, 1'b0);
    for (int k = 1; k < NR; k++) push_packet(k, 1, 1'b1, 1'b0);
    for (int t = 0; t < 14; t++) begin
      tick();
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rr.ready cyc %0d: got %b expected %b", cyc, obs_ready, exp_ready); end
      checks++; if (obs_write !== exp_write || obs_data !== exp_data) begin errors++; $display("FAIL rr.write cyc %0d: got %b/%h expected %b/%h", cyc, obs_write, obs_data, exp_write, exp_data); end
      checks++; if (obs_busy !== exp_busy || obs_grant !== exp_grant) begin errors++; $display("FAIL rr.grant cyc %0d: got busy %b grant %0d expected busy %b grant %0d", cyc, obs_busy, obs_grant, exp_busy, exp_grant); end
      if (obs_busy === 1'b1 && !prev_busy) begin
        grants.push_back(int'(obs_grant));
        rise_at.push_back(t);
      end
      prev_busy = (obs_busy === 1'b1);
    end
    checks++;
    if (grants.size() != 5) begin errors++; $display("FAIL rr.count: got %0d grants expected 5", grants.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (grants[i] != want[i]) begin errors++; $display("FAIL rr.order[%0d]: got %0d expected %0d", i, grants[i], want[i]); end
        if (i > 0) begin
          checks++; if (rise_at[i] - rise_at[i-1] != 2) begin errors++; $display("FAIL rr.gap[%0d]: got %0d cycles expected 2", i, rise_at[i] - rise_at[i-1]); end
        end
      end
    end
  endtask

  task automatic test_min_space();
    int wrs = 0;
    apply_reset();
    count_drv = 11'd2040;
    push_packet(1, 2, 1'b1, 1'b0);
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++; if (obs_busy !== 1'b0 || obs_ready !== '0) begin errors++; $display("FAIL space.no_grant cyc %0d: got busy %b ready %b expected 0/0000", cyc, obs_busy, obs_ready); end
    end
    count_drv = 11'd2032;
    tick();
    tick();
    checks++; if (obs_busy !== 1'b1 || obs_grant !== 2'd1) begin errors++; $display("FAIL space.grant: got busy %b grant %0d expected busy 1 grant 1", obs_busy, obs_grant); end
    if (obs_write === 1'b1) wrs++;
    for (int t = 0; t < 4; t++) begin
      tick();
      checks++; if (obs_write !== exp_write || obs_data !== exp_data || obs_busy !== exp_busy) begin errors++; $display("FAIL space.burst cyc %0d: got %b/%h/%b expected %b/%h/%b", cyc, obs_write, obs_data, obs_busy, exp_write, exp_data, exp_busy); end
      if (obs_write === 1'b1) wrs++;
    end
    checks++; if (wrs != 2) begin errors++; $display("FAIL space.write_count: got %0d expected 2", wrs); end
  endtask

  task automatic test_full_stall();
    int wrs = 0;
    int stall_left;
    logic [DW-1:0] want;
    apply_reset();
    push_packet(2, 5, 1'b1, 1'b1);
    stall_left = $urandom_range(2, 5);
    for (int t = 0; t < 20; t++) begin
      full_drv = (wrs == 1 && stall_left > 0);
      if (full_drv) stall_left--;
      tick();
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL stall.ready cyc %0d: got %b expected %b", cyc, obs_ready, exp_ready); end
      checks++; if (obs_write !== exp_write || obs_data !== exp_data) begin errors++; $display("FAIL stall.write cyc %0d: got %b/%h expected %b/%h", cyc, obs_write, obs_data, exp_write, exp_data); end
      checks++; if (obs_busy !== exp_busy || obs_grant !== exp_grant) begin errors++; $display("FAIL stall.grant cyc %0d: got %b/%0d expected %b/%0d", cyc, obs_busy, obs_grant, exp_busy, exp_grant); end
      if (full_drv) begin
        checks++; if (obs_ready !== '0 || obs_write !== 1'b0 || obs_busy !== 1'b1) begin errors++; $display("FAIL stall.held cyc %0d: got ready %b write %b busy %b expected 0000/0/1", cyc, obs_ready, obs_write, obs_busy); end
      end
      if (obs_write === 1'b1) begin
        wrs++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stall.extra_write: got data %h expected none", obs_data); end
        else begin
          want = exp_q.pop_front();
          if (obs_data !== want) begin errors++; $display("FAIL stall.sb_data: got %h expected %h", obs_data, want); end
        end
      end
    end
    full_drv = 1'b0;
    checks++; if (wrs != 5 || exp_q.size() != 0) begin errors++; $display("FAIL stall.complete: got %0d writes, %0d left expected 5, 0", wrs, exp_q.size()); end
  endtask

  task automatic test_truncation();
    int grants[$];
    int first_wrs = 0;
    int truncs = 0;
    bit prev_busy = 1'b0;
    logic [DW-1:0] want;
    apply_reset();
    push_packet(1, 70, 1'b0, 1'b0);
    for (int i = 0; i < MAX_BURST; i++) begin
      logic [DW:0] b;
      b = src_q[1][i];
      exp_q.push_back(b[DW-1:0]);
    end
    push_packet(3, 1, 1'b1, 1'b0);
    for (int t = 0; t < 80; t++) begin
      tick();
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL trunc.ready cyc %0d: got %b expected %b", cyc, obs_ready, exp_ready); end
      checks++; if (obs_write !== exp_write || obs_data !== exp_data) begin errors++; $display("FAIL trunc.write cyc %0d: got %b/%h expected %b/%h", cyc, obs_write, obs_data, exp_write, exp_data); end
      checks++; if (obs_busy !== exp_busy || obs_grant !== exp_grant) begin errors++; $display("FAIL trunc.grant cyc %0d: got %b/%0d expected %b/%0d", cyc, obs_busy, obs_grant, exp_busy, exp_grant); end
      checks++; if (obs_trunc !== exp_trunc) begin errors++; $display("FAIL trunc.pulse cyc %0d: got %b expected %b", cyc, obs_trunc, exp_trunc); end
      if (obs_busy === 1'b1 && !prev_busy) grants.push_back(int'(obs_grant));
      prev_busy = (obs_busy === 1'b1);
      if (obs_trunc === 1'b1) truncs++;
      if (obs_write === 1'b1 && grants.size() == 1) begin
        first_wrs++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL trunc.extra_write: got data %h expected none", obs_data); end
        else begin
          want = exp_q.pop_front();
          if (obs_data !== want) begin errors++; $display("FAIL trunc.sb_data: got %h expected %h", obs_data, want); end
        end
      end
    end
    checks++; if (first_wrs != MAX_BURST) begin errors++; $display("FAIL trunc.beats: got %0d expected %0d", first_wrs, MAX_BURST); end
    checks++; if (truncs != 1) begin errors++; $display("FAIL trunc.pulses: got %0d expected 1", truncs); end
    checks++; if (grants.size() < 2 || grants[1] != 3) begin errors++; $display("FAIL trunc.next_grant: got %0d grants (second %0d) expected second 3", grants.size(), (grants.size() > 1) ? grants[1] : -1); end
    // Requester 1 ran dry without a last beat: grant must still be held.
    checks++; if (obs_busy !== 1'b1 || obs_grant !== 2'd1 || obs_write !== 1'b0) begin errors++; $display("FAIL trunc.wait_last: got busy %b grant %0d write %b expected 1/1/0", obs_busy, obs_grant, obs_write); end
  endtask

  task automatic test_reset_mid_burst();
    int wrs = 0;
    int first_grant = -1;
    int budget = 0;
    apply_reset();
    push_packet(2, 10, 1'b1, 1'b0);
    while (wrs < 3 && budget < 12) begin
      tick();
      budget++;
      if (obs_write === 1'b1) wrs++;
    end
    checks++; if (wrs != 3) begin errors++; $display("FAIL rstmid.setup: got %0d writes expected 3", wrs); end
    @(posedge clk_write);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL rstmid.ready: got %b expected 0000", req_ready); end
    checks++; if (fifo_write !== 1'b0 || fifo_data_write !== '0) begin errors++; $display("FAIL rstmid.write: got %b/%h expected 0/00", fifo_write, fifo_data_write); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid.busy: got %b expected 0", busy); end
    model_reset();
    push_packet(3, 2, 1'b1, 1'b0);
    push_packet(1, 2, 1'b1, 1'b0);
    @(negedge clk_write);
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++; if (obs_busy !== exp_busy || obs_grant !== exp_grant || obs_write !== exp_write || obs_data !== exp_data) begin errors++; $display("FAIL rstmid.model cyc %0d: got %b/%0d/%b/%h expected %b/%0d/%b/%h", cyc, obs_busy, obs_grant, obs_write, obs_data, exp_busy, exp_grant, exp_write, exp_data); end
      if (obs_busy === 1'b1 && first_grant < 0) first_grant = int'(obs_grant);
    end
    checks++; if (first_grant != 1) begin errors++; $display("FAIL rstmid.first_grant: got %0d expected 1", first_grant); end
  endtask

  task automatic test_random();
    int total = 0;
    int wrs = 0;
    int budget = 0;
    int pending;
    apply_reset();
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 8);
      push_packet($urandom_range(0, NR - 1), len, 1'b1, 1'b0);
      total += len;
    end
    gap_en = 1'b1;
    pending = total;
    while ((pending > 0 || m_burst) && budget < 3000) begin
      full_drv = ($urandom_range(0, 7) == 0);
      count_drv = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2030, 2047)) : 11'($urandom_range(0, 1000));
      tick();
      budget++;
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand.ready cyc %0d: got %b expected %b", cyc, obs_ready, exp_ready); end
      checks++; if (obs_write !== exp_write || obs_data !== exp_data) begin errors++; $display("FAIL rand.write cyc %0d: got %b/%h expected %b/%h", cyc, obs_write, obs_data, exp_write, exp_data); end
      checks++; if (obs_busy !== exp_busy || obs_grant !== exp_grant) begin errors++; $display("FAIL rand.grant cyc %0d: got %b/%0d expected %b/%0d", cyc, obs_busy, obs_grant, exp_busy, exp_grant); end
      checks++; if (obs_trunc !== 1'b0) begin errors++; $display("FAIL rand.trunc cyc %0d: got %b expected 0", cyc, obs_trunc); end
      if (obs_write === 1'b1) wrs++;
      if (exp_write) pending--;
    end
    gap_en = 1'b0; full_drv = 1'b0;
    checks++; if (budget >= 3000) begin errors++; $display("FAIL rand.timeout: got %0d beats left expected 0", pending); end
    checks++; if (wrs != total) begin errors++; $display("FAIL rand.write_count: got %0d expected %0d", wrs, total); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n = 1'b1;
    model_reset();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_min_space();
    test_full_stall();
    test_truncation();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
